// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for the RV32M divide group
// (div/divu/rem/remu). One op in flight; request via valid/ready, tagged
// result held on resp_* until the consumer takes it.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow are resolved at accept and presented one cycle later instead
// of running the full iteration.
module div_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             op_rem;
  logic             q_neg;
  logic             r_neg;
  logic [TAG_W-1:0] tag;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  quo;

  // accept-side decode
  logic             signed_op;
  logic             rs1_neg;
  logic             rs2_neg;
  logic [XLEN-1:0]  abs_rs1;
  logic [XLEN-1:0]  abs_rs2;
  logic             accept;

  // one restoring step and the final sign fix-up
  logic [XLEN:0]    rem_sh;
  logic             step_ge;
  logic [XLEN-1:0]  rem_nx;
  logic [XLEN-1:0]  quo_nx;
  logic [XLEN-1:0]  quo_res;
  logic [XLEN-1:0]  rem_res;
  logic [XLEN-1:0]  calc_result;

  // special-case shortcut at accept
  logic             fast_hit;
  logic [XLEN-1:0]  fast_result;

  // Request handshake: only an idle, non-flushed sequencer takes work
  always_comb begin
    req_ready = 1'b0;
    req_ready = (state == S_IDLE) && !flush;
  end

  assign accept = req_valid && req_ready;

  // Operand sign handling: magnitudes for signed ops, raw values for unsigned
  always_comb begin
    signed_op = 1'b0;
    rs1_neg   = 1'b0;
    rs2_neg   = 1'b0;
    abs_rs1   = req_rs1;
    abs_rs2   = req_rs2;
    signed_op = !req_op[0];
    rs1_neg   = signed_op && req_rs1[XLEN-1];
    rs2_neg   = signed_op && req_rs2[XLEN-1];
    if (rs1_neg) abs_rs1 = -req_rs1;
    if (rs2_neg) abs_rs2 = -req_rs2;
  end

  // Restoring step: shift {rem,quo} left, subtract divisor when it fits
  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    step_ge = rem_sh >= {1'b0, divisor};
    rem_nx  = rem_sh[XLEN-1:0];
    if (step_ge) rem_nx = XLEN'(rem_sh - {1'b0, divisor});
    quo_nx  = {quo[XLEN-2:0], step_ge};
  end

  // Final result: a zero divisor keeps the all-ones quotient unsigned-looking
  always_comb begin
    quo_res = quo_nx;
    rem_res = rem_nx;
    if (q_neg && (divisor != '0)) quo_res = -quo_nx;
    if (r_neg) rem_res = -rem_nx;
    calc_result = op_rem ? rem_res : quo_res;
  end

`ifdef DIV_FAST_SPECIAL_EN
  // Divide-by-zero and signed overflow resolved without iterating
  always_comb begin
    fast_hit    = 1'b0;
    fast_result = '0;
    if (req_rs2 == '0) begin
      fast_hit    = 1'b1;
      fast_result = req_op[1] ? req_rs1 : '1;
    end else if (signed_op && (req_rs1 == XMIN) && (req_rs2 == '1)) begin
      fast_hit    = 1'b1;
      fast_result = req_op[1] ? '0 : XMIN;
    end
  end
`else
  // Special cases take the normal iterative path
  always_comb begin
    fast_hit    = 1'b0;
    fast_result = '0;
  end
`endif

  // Sequencer: state, datapath registers and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      counter     <= '0;
      op_rem      <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      tag         <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_tag    <= '0;
      busy        <= 1'b0;
    end else if (flush) begin
      state      <= S_IDLE;
      counter    <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_rem  <= req_op[1];
            tag     <= req_tag;
            divisor <= abs_rs2;
            quo     <= abs_rs1;
            rem     <= '0;
            q_neg   <= rs1_neg ^ rs2_neg;
            r_neg   <= rs1_neg;
            counter <= '0;
            busy    <= 1'b1;
            if (fast_hit) begin
              state       <= S_DONE;
              resp_valid  <= 1'b1;
              resp_result <= fast_result;
              resp_tag    <= req_tag;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (counter == CNT_LAST) begin
            state       <= S_DONE;
            resp_valid  <= 1'b1;
            resp_result <= calc_result;
            resp_tag    <= tag;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq. The driver pushes the expected
// response (from an RV32M arithmetic model) on each accept; a monitor pops
// and compares whenever the DUT presents a response.
module tb_div_seq;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [31:0] XMIN = 32'h8000_0000;
`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [XLEN-1:0]  req_rs1 = '0;
  logic [XLEN-1:0]  req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [XLEN-1:0]  resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  div_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M divide semantics
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == XMIN) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return XMIN;
        return $signed(a) / $signed(b);
      end
      2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (!op[0] && (a == XMIN) && (b == 32'hFFFF_FFFF));
    return (FAST && special) ? 1 : 33;
  endfunction

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t);
    exp_t e;
    e.res = ref_div(op, a, b);
    e.tag = t;
    e.acc = cyc;
    e.lat = ref_lat(op, a, b);
    sb.push_back(e);
  endtask

  // Present one request and return at the cycle after it is accepted
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    int n;
    req_op = op; req_rs1 = a; req_rs2 = b; req_tag = t; req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout op %0d tag %0d", op, t);
        break;
      end
    end
    if (req_ready) push_exp(op, a, b, t);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending %0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_valid_timeout got 0 want 1");
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 20));
      2: return XMIN;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Random consumer back-pressure when enabled
  initial forever begin
    @(posedge clk); #2;
    if (rand_rdy) resp_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compare every presented response against the scoreboard front
  initial begin
    bit   hold;
    exp_t e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        hold = 1'b0;
        continue;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp got tag %0d result %h want no response", resp_tag, resp_result);
        end else begin
          e = sb[0];
          if (!hold) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk(hold ? "held_result" : "result", resp_result, e.res);
          chk(hold ? "held_tag" : "tag", 32'(resp_tag), 32'(e.tag));
          if (resp_ready) begin
            void'(sb.pop_front());
            hold = 1'b0;
          end else begin
            hold = 1'b1;
          end
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;

    // reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // directed arithmetic and special cases
    issue(2'd1, 32'd100, 32'd7, 5'd3);             drain();
    issue(2'd3, 32'd100, 32'd7, 5'd4);             drain();
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5);       drain();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6);       drain();
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 5'd7);       drain();
    issue(2'd0, 32'd5, 32'd0, 5'd8);               drain();
    issue(2'd2, 32'hFFFF_FFFB, 32'd0, 5'd9);       drain();
    issue(2'd1, 32'hDEAD_BEEF, 32'd0, 5'd10);      drain();
    issue(2'd0, XMIN, 32'hFFFF_FFFF, 5'd11);       drain();
    issue(2'd2, XMIN, 32'hFFFF_FFFF, 5'd12);       drain();
    issue(2'd1, XMIN, 32'hFFFF_FFFF, 5'd13);       drain();

    // back-pressure in DONE, then back-to-back op after the handshake
    resp_ready = 1'b0;
    issue(2'd1, 32'd1000, 32'd9, 5'd14);
    wait_valid();
    repeat (10) begin
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_op = 2'd1; req_rs1 = 32'd9; req_rs2 = 32'd3; req_tag = 5'd15; req_valid = 1'b1;
    @(negedge clk);
    chk("no_accept_in_done", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_hs", 32'(req_ready), 32'd1);
    if (req_ready) push_exp(2'd1, 32'd9, 32'd3, 5'd15);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // flush mid-calculation
    issue(2'd1, 32'd77, 32'd5, 5'd16);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_req_ready", 32'(req_ready), 32'd1);
    chk("post_flush_busy", 32'(busy), 32'd0);
    chk("post_flush_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    issue(2'd1, 32'd9, 32'd3, 5'd17);              drain();

    // flush while a result waits in DONE
    resp_ready = 1'b0;
    issue(2'd3, 32'd50, 32'd8, 5'd18);
    wait_valid();
    @(posedge clk); #1;
    flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("done_flush_valid", 32'(resp_valid), 32'd0);
    chk("done_flush_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // reset mid-calculation
    issue(2'd0, 32'd1234, 32'd11, 5'd19);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_resp_result", resp_result, 32'd0);
    chk("midrst_resp_tag", 32'(resp_tag), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    issue(2'd1, 32'd9, 32'd3, 5'd20);              drain();

    // randomized ops with random consumer back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = rand_operand();
      b  = rand_operand();
      issue(op, a, b, 5'($urandom_range(0, 31)));
    end
    drain();
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
